// File: rtl/mips_cpu_muldiv.sv
// mips_cpu_muldiv: iterative MULT/MULTU/DIV/DIVU unit holding HI/LO, one bit per cycle.
module mips_cpu_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t state, state_nx;
  logic [1:0] op_r;
  logic sa, sb;
  logic [WIDTH-1:0] ma, mb, a_raw;
  logic [CNT_W-1:0] cnt;
  logic [2*WIDTH-1:0] acc;
  logic a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs, addend, rem_nx, q_fin, r_fin, hi_fin, lo_fin;
  logic [WIDTH:0] trial, diff;
  logic ge;
  logic [2*WIDTH-1:0] mul_nx, div_nx, prod;
  always_comb begin
    a_neg = ~op[0] & a[WIDTH-1];
    b_neg = ~op[0] & b[WIDTH-1];
    a_abs = a_neg ? -a : a;
    b_abs = b_neg ? -b : b;
    addend = mb[cnt] ? ma : '0;
    mul_nx = {acc[2*WIDTH-2:0], 1'b0} + {{WIDTH{1'b0}}, addend};
    // Restoring step: remainder lives in acc high half, quotient shifts into low half.
    trial = {acc[2*WIDTH-1:WIDTH], ma[cnt]};
    diff = trial - {1'b0, mb};
    ge = trial >= {1'b0, mb};
    rem_nx = ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    div_nx = {rem_nx, acc[WIDTH-2:0], ge};
    prod = (~op_r[0] & (sa ^ sb)) ? -acc : acc;
    q_fin = (~op_r[0] & (sa ^ sb)) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    r_fin = (~op_r[0] & sa) ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    hi_fin = ~op_r[1] ? prod[2*WIDTH-1:WIDTH] : (mb == '0 ? a_raw : r_fin);
    lo_fin = ~op_r[1] ? prod[WIDTH-1:0] : (mb == '0 ? '1 : q_fin);
  end
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (start ? RUN : IDLE) :
               state == RUN ? (cnt == '0 ? FIN : RUN) : IDLE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  assign busy = state != IDLE;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
      done <= 1'b0;
      acc <= '0;
      cnt <= '0;
      op_r <= '0;
      sa <= 1'b0;
      sb <= 1'b0;
      ma <= '0;
      mb <= '0;
      a_raw <= '0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (hi_we) hi <= wdata;
        if (lo_we) lo <= wdata;
        if (start) begin
          op_r <= op;
          sa <= a_neg;
          sb <= b_neg;
          ma <= a_abs;
          mb <= b_abs;
          a_raw <= a;
          acc <= '0;
          cnt <= CNT_W'(WIDTH - 1);
        end
      end else if (state == RUN) begin
        acc <= op_r[1] ? div_nx : mul_nx;
        cnt <= cnt - 1'b1;
      end else begin
        hi <= hi_fin;
        lo <= lo_fin;
        done <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// tb_mips_cpu_muldiv: directed checks of the multiply/divide unit.
module tb_mips_cpu_muldiv;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, hi_we = 1'b0, lo_we = 1'b0;
  logic [1:0] op = 2'b00;
  logic [31:0] a = '0, b = '0, wdata = '0;
  logic busy, done;
  logic [31:0] hi, lo;
  int total = 0, bad = 0;
  mips_cpu_muldiv dut (.clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .busy(busy), .done(done), .hi(hi), .lo(lo));
  always #5 clk = ~clk;
  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       output int bcyc, output bit overlap);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0; op = ~o; a = 32'h5A5A_1234; b = 32'h0F0F_0F0F;
    bcyc = 0; overlap = 0;
    while (busy && bcyc < 100) begin
      if (done) overlap = 1;
      bcyc++;
      @(negedge clk);
    end
  endtask
  task automatic test_reset;
    @(negedge clk);
    total++; if ({busy, done, hi, lo} !== 66'd0) begin bad++; $display("FAIL reset: busy=%b done=%b hi=%h lo=%h want all 0", busy, done, hi, lo); end
    reset = 1'b0;
  endtask
  task automatic test_mult;
    int n; bit ov;
    do_op(2'b00, 32'hFFFF_FFFD, 32'd5, n, ov);
    total++; if (n !== 33) begin bad++; $display("FAIL mult_busy: got %0d want 33", n); end
    total++; if (done !== 1'b1 || ov) begin bad++; $display("FAIL mult_done: done=%b overlap=%b want 1/0", done, ov); end
    total++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFF1) begin bad++; $display("FAIL mult: got %h_%h want FFFFFFFF_FFFFFFF1", hi, lo); end
    @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL done_pulse: got %b want 0", done); end
  endtask
  task automatic test_multu;
    int n; bit ov;
    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n, ov);
    total++; if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001) begin bad++; $display("FAIL multu: got %h_%h want FFFFFFFE_00000001", hi, lo); end
  endtask
  task automatic test_div;
    int n; bit ov;
    do_op(2'b10, 32'hFFFF_FFF9, 32'd2, n, ov);
    total++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin bad++; $display("FAIL div: got %h_%h want FFFFFFFF_FFFFFFFD", hi, lo); end
    do_op(2'b10, 32'd100, 32'hFFFF_FFF9, n, ov);
    total++; if ({hi, lo} !== 64'h0000_0002_FFFF_FFF2) begin bad++; $display("FAIL div_negb: got %h_%h want 00000002_FFFFFFF2", hi, lo); end
  endtask
  task automatic test_div_zero;
    int n; bit ov;
    do_op(2'b11, 32'd7, 32'd0, n, ov);
    total++; if (n !== 33 || done !== 1'b1) begin bad++; $display("FAIL divu0_timing: busy=%0d done=%b want 33/1", n, done); end
    total++; if ({hi, lo} !== 64'h0000_0007_FFFF_FFFF) begin bad++; $display("FAIL divu0: got %h_%h want 00000007_FFFFFFFF", hi, lo); end
    do_op(2'b10, 32'hFFFF_FFF0, 32'd0, n, ov);
    total++; if ({hi, lo} !== 64'hFFFF_FFF0_FFFF_FFFF) begin bad++; $display("FAIL div0: got %h_%h want FFFFFFF0_FFFFFFFF", hi, lo); end
  endtask
  task automatic test_div_ovf;
    int n; bit ov;
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, n, ov);
    total++; if ({hi, lo} !== 64'h0000_0000_8000_0000) begin bad++; $display("FAIL div_ovf: got %h_%h want 00000000_80000000", hi, lo); end
  endtask
  task automatic test_reset_mid;
    int n; bit ov;
    @(negedge clk);
    hi_we = 1'b1; wdata = 32'hABCD_0001;
    @(negedge clk);
    hi_we = 1'b0; op = 2'b00; a = 32'd3; b = 32'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy: got %b want 1", busy); end
    #2 reset = 1'b1;
    #1;
    total++; if ({busy, hi, lo} !== 65'd0) begin bad++; $display("FAIL mid_reset: busy=%b hi=%h lo=%h want 0", busy, hi, lo); end
    @(negedge clk);
    reset = 1'b0;
    do_op(2'b11, 32'd100, 32'd7, n, ov);
    total++; if ({hi, lo} !== {32'd2, 32'd14}) begin bad++; $display("FAIL after_reset_divu: got %h_%h want 00000002_0000000e", hi, lo); end
  endtask
  task automatic test_sequencing;
    int n;
    @(negedge clk);
    hi_we = 1'b1; wdata = 32'd1234;
    @(negedge clk);
    hi_we = 1'b0;
    total++; if (hi !== 32'd1234) begin bad++; $display("FAIL mthi: got %0d want 1234", hi); end
    lo_we = 1'b1; wdata = 32'd77;
    @(negedge clk);
    lo_we = 1'b0;
    total++; if (lo !== 32'd77) begin bad++; $display("FAIL mtlo: got %0d want 77", lo); end
    op = 2'b01; a = 32'd2; b = 32'd3; start = 1'b1;
    @(negedge clk);
    op = 2'b11; a = 32'd9; b = 32'd3; lo_we = 1'b1; hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
    repeat (3) @(negedge clk);
    total++; if (lo !== 32'd77 || hi !== 32'd1234) begin bad++; $display("FAIL mt_in_run: hi=%h lo=%h want 000004d2/0000004d", hi, lo); end
    start = 1'b0; lo_we = 1'b0; hi_we = 1'b0;
    n = 0;
    while (!done && n < 100) begin n++; @(negedge clk); end
    total++; if (n !== 30) begin bad++; $display("FAIL start_in_run_timing: got %0d want 30", n); end
    total++; if ({hi, lo} !== 64'd6) begin bad++; $display("FAIL start_in_run: got %h_%h want 00000000_00000006", hi, lo); end
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL no_queue: busy=%b want 0", busy); end
  endtask
  task automatic test_back_to_back;
    int n;
    @(negedge clk);
    op = 2'b01; a = 32'd2; b = 32'd3; start = 1'b1;
    n = 0;
    do begin n++; @(negedge clk); end while (!done && n < 100);
    total++; if (done !== 1'b1 || n !== 34 || {hi, lo} !== 64'd6) begin bad++; $display("FAIL b2b_first: done=%b n=%0d hi=%h lo=%h want 1/34/0/6", done, n, hi, lo); end
    a = 32'd4; b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    total++; if (busy !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL b2b_busy: busy=%b done=%b want 1/0", busy, done); end
    n = 0;
    while (!done && n < 100) begin n++; @(negedge clk); end
    total++; if (n !== 33 || {hi, lo} !== 64'd20) begin bad++; $display("FAIL b2b_second: n=%0d hi=%h lo=%h want 33/0/20", n, hi, lo); end
  endtask
  initial begin
    test_reset;
    test_mult;
    test_multu;
    test_div;
    test_div_zero;
    test_div_ovf;
    test_reset_mid;
    test_sequencing;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
